// File: rtl/alu_arb.sv
// Two-requester arbiter sharing one combinational ALU, with a one-entry response buffer per requester.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority (requester 0 wins).
module alu_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_op,
   input  logic        req0_op_imm,
   input  logic [2:0]  req0_funct3,
   input  logic [6:0]  req0_funct7,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_op,
   input  logic        req1_op_imm,
   input  logic [2:0]  req1_funct3,
   input  logic [6:0]  req1_funct7,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_t,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_t,
   output logic        alu_op,
   output logic        alu_op_imm,
   output logic [2:0]  alu_funct3,
   output logic [6:0]  alu_funct7,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_t
);

   logic        elig0, elig1;
   logic        grant0, grant1;
   logic        rsp0_valid_q, rsp0_valid_d;
   logic        rsp1_valid_q, rsp1_valid_d;
   logic [31:0] rsp0_t_q, rsp0_t_d;
   logic [31:0] rsp1_t_q, rsp1_t_d;
`ifdef ALU_ARB_RR_EN
   logic        prio_q, prio_d;
`endif

   // A full buffer that drains this cycle can accept a new result without a bubble.
   // Grants are gated by rst_n so nothing handshakes while reset is held.
   always_comb begin
      elig0 = req0_valid & (~rsp0_valid_q | rsp0_ready);
      elig1 = req1_valid & (~rsp1_valid_q | rsp1_ready);
`ifdef ALU_ARB_RR_EN
      grant0 = rst_n & elig0 & (~elig1 | ~prio_q);
      grant1 = rst_n & elig1 & (~elig0 | prio_q);
`else
      grant0 = rst_n & elig0;
      grant1 = rst_n & elig1 & ~elig0;
`endif
   end

   always_comb begin
      alu_op     = 1'b0;
      alu_op_imm = 1'b0;
      alu_funct3 = 3'd0;
      alu_funct7 = 7'd0;
      alu_a      = 32'd0;
      alu_b      = 32'd0;
      if (grant0) begin
         alu_op     = req0_op;
         alu_op_imm = req0_op_imm;
         alu_funct3 = req0_funct3;
         alu_funct7 = req0_funct7;
         alu_a      = req0_a;
         alu_b      = req0_b;
      end else if (grant1) begin
         alu_op     = req1_op;
         alu_op_imm = req1_op_imm;
         alu_funct3 = req1_funct3;
         alu_funct7 = req1_funct7;
         alu_a      = req1_a;
         alu_b      = req1_b;
      end
   end

   always_comb begin
      rsp0_valid_d = grant0 | (rsp0_valid_q & ~rsp0_ready);
      rsp1_valid_d = grant1 | (rsp1_valid_q & ~rsp1_ready);
      rsp0_t_d     = grant0 ? alu_t : rsp0_t_q;
      rsp1_t_d     = grant1 ? alu_t : rsp1_t_q;
`ifdef ALU_ARB_RR_EN
      prio_d = prio_q;
      if (grant0)      prio_d = 1'b1;
      else if (grant1) prio_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_t_q     <= 32'd0;
         rsp1_t_q     <= 32'd0;
      end else begin
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_t_q     <= rsp0_t_d;
         rsp1_t_q     <= rsp1_t_d;
      end
   end

`ifdef ALU_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prio_q <= 1'b0;
      else        prio_q <= prio_d;
   end
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_t     = rsp0_t_q;
   assign rsp1_t     = rsp1_t_q;

endmodule
